fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the byte-addressed, combinational-read instruction ROM. It owns the fetch PC, drives the ROM address, and captures each returned 32-bit word with its PC into a small fetch queue. It presents instructions to decode through a valid/ready handshake, and accepts redirects from branch/jump resolution. It sits between the ROM and the decode stage of the core.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_ctrl_if.sv | 12 +
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/fetch_ctrl.sv | 78 +++++++
 tb/tb_fetch_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch slice.
package fetch_pkg;

  localparam int INSTR_BYTES           = 4;
  localparam int DEFAULT_ADDRESS_WIDTH = 12;

  // One captured fetch: the ROM word together with the PC it was read from.
  typedef struct packed {
    logic [31:0]                      instr;
    logic [DEFAULT_ADDRESS_WIDTH-1:0] pc;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-to-decode handshake: queue head plus decode's ready.
interface fetch_ctrl_if #(
  parameter int ADDRESS_WIDTH = fetch_pkg::DEFAULT_ADDRESS_WIDTH
);
  logic                     out_valid;
  logic [31:0]              out_instr;
  logic [ADDRESS_WIDTH-1:0] out_pc;
  logic                     out_ready;

  modport master (output out_valid, out_instr, out_pc, input out_ready);
  modport slave  (input out_valid, out_instr, out_pc, output out_ready);
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush. Pointers carry one extra wrap bit so
// full and empty are distinguishable; the head is read through the
// registered read pointer so it holds steady until popped.
module fetch_fifo #(
  parameter int WIDTH = 44,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Pointer next-state: flush empties the queue and wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !flush) begin
      mem_q[wr_ptr_q[IW-1:0]] <= din;
    end
  end

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == PW'(DEPTH));
  assign head  = mem_q[rd_ptr_q[IW-1:0]];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, reads the combinational
// ROM, queues {instr, pc} pairs and hands them to decode; redirects flush
// the queue and restart fetch at the word-aligned target.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int RESET_PC      = 0,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [31:0]              rom_instr,
  input  logic                     halt,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  fetch_ctrl_if.master             dec,
  output logic                     misalign_err
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = 32 + ADDRESS_WIDTH;

  logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                     misalign_q, misalign_d;
  logic                     push, pop, fifo_full;
  logic [CW-1:0]            fifo_count;
  logic [EW-1:0]            fifo_head;

  // A full queue can still accept when its head leaves in the same cycle.
  assign pop  = dec.out_valid && dec.out_ready;
  assign push = !halt && !redirect_valid && (!fifo_full || pop);

  // PC / misalign next-state: redirect overrides sequential advance.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    misalign_d = 1'b0;
    if (redirect_valid) begin
      fetch_pc_d = ADDRESS_WIDTH'(align(32'(redirect_pc)));
      misalign_d = |redirect_pc[1:0];
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + ADDRESS_WIDTH'(INSTR_BYTES);
    end
  end

  // PC and misalign-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= ADDRESS_WIDTH'(RESET_PC);
      misalign_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      misalign_q <= misalign_d;
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({rom_instr, fetch_pc_q}),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full)
  );

  assign rom_addr      = fetch_pc_q;
  assign misalign_err  = misalign_q;
  assign dec.out_valid = (fifo_count != '0);
  assign dec.out_instr = fifo_head[EW-1:ADDRESS_WIDTH];
  assign dec.out_pc    = fifo_head[ADDRESS_WIDTH-1:0];

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: queue-based reference model checked every cycle,
// plus directed literal expectations from the test plan.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int AW    = 12;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_instr;
  logic          halt;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          misalign_err;

  int checks = 0;
  int errors = 0;

  fetch_ctrl_if #(.ADDRESS_WIDTH(AW)) dec_if ();

  fetch_ctrl #(
    .ADDRESS_WIDTH (AW),
    .RESET_PC      (0),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_instr      (rom_instr),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec            (dec_if),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  // ROM contents: the three program words, then an address-tagged pattern.
  function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
    case (a)
      12'h000: return 32'h0000_0013;
      12'h004: return 32'h0010_0093;
      12'h008: return 32'h0020_0113;
      default: return {8'h5A, a, a};
    endcase
  endfunction

  assign rom_instr = rom_word(rom_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue of words decode has yet to take, the PC the
  // fetcher reads next, and the misalign flag.
  fetch_entry_t  mq[$];
  logic [AW-1:0] m_pc  = '0;
  logic          m_mis = 1'b0;
  bit            m_take;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_pc  = '0;
      m_mis = 1'b0;
    end else begin
      m_take = (mq.size() != 0) && dec_if.out_ready;
      if (redirect_valid) begin
        mq.delete();
        m_pc  = {redirect_pc[AW-1:2], 2'b00};
        m_mis = (redirect_pc[1:0] != 2'b00);
      end else begin
        m_mis = 1'b0;
        if (m_take) void'(mq.pop_front());
        if (!halt && mq.size() < DEPTH) begin
          mq.push_back('{instr: rom_word(m_pc), pc: m_pc});
          m_pc = m_pc + 12'd4;
        end
      end
    end
  end

  // Compare DUT outputs with the model on every falling edge.
  always @(negedge clk) begin
    chk("m_valid", 64'(dec_if.out_valid), 64'(mq.size() != 0));
    chk("m_rom_addr", 64'(rom_addr), 64'(m_pc));
    chk("m_misalign", 64'(misalign_err), 64'(m_mis));
    if (mq.size() != 0) begin
      chk("m_pc", 64'(dec_if.out_pc), 64'(mq[0].pc));
      chk("m_instr", 64'(dec_if.out_instr), 64'(mq[0].instr));
      if (dec_if.out_ready)
        $display("accept pc=0x%03h instr=0x%08h t=%0t", dec_if.out_pc, dec_if.out_instr, $time);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_head(input string name, input logic [AW-1:0] pc);
    chk({name, "_valid"}, 64'(dec_if.out_valid), 64'd1);
    chk({name, "_pc"}, 64'(dec_if.out_pc), 64'(pc));
  endtask

  task automatic do_redirect(input logic [AW-1:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    cyc(1);
    redirect_valid = 1'b0;
  endtask

  logic [15:0] rdy_pat  = 16'b1011_0110_1110_0101;
  logic [15:0] halt_pat = 16'b0000_1100_0001_0000;

  initial begin
    rst_n = 1'b0;
    halt = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    dec_if.out_ready = 1'b1;

    // Reset state.
    cyc(2);
    chk("rst_valid", 64'(dec_if.out_valid), 64'd0);
    chk("rst_rom_addr", 64'(rom_addr), 64'h000);
    chk("rst_pc", 64'(dec_if.out_pc), 64'h000);
    chk("rst_instr", 64'(dec_if.out_instr), 64'h0);
    chk("rst_misalign", 64'(misalign_err), 64'd0);

    // Straight-line fetch, ready held high.
    #2 rst_n = 1'b1;
    cyc(1);
    expect_head("t1_a", 12'h000);
    chk("t1_a_instr", 64'(dec_if.out_instr), 64'h0000_0013);
    cyc(1);
    expect_head("t1_b", 12'h004);
    chk("t1_b_instr", 64'(dec_if.out_instr), 64'h0010_0093);
    cyc(1);
    expect_head("t1_c", 12'h008);
    chk("t1_c_instr", 64'(dec_if.out_instr), 64'h0020_0113);

    // Decode stalled from reset: queue fills, fetch PC parks at 0x008.
    cyc(1);
    #2 rst_n = 1'b0;
    #1 chk("rst2_valid", 64'(dec_if.out_valid), 64'd0);
    chk("rst2_rom_addr", 64'(rom_addr), 64'h000);
    dec_if.out_ready = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("stall_pc", 64'(dec_if.out_pc), 64'h000);
      if (i >= 1) chk("stall_rom_addr", 64'(rom_addr), 64'h008);
    end
    dec_if.out_ready = 1'b1;
    cyc(1);
    expect_head("drain_b", 12'h004);
    cyc(1);
    expect_head("drain_c", 12'h008);

    // Redirect while full.
    dec_if.out_ready = 1'b0;
    cyc(3);
    do_redirect(12'h100);
    chk("rd_bubble_valid", 64'(dec_if.out_valid), 64'd0);
    chk("rd_rom_addr", 64'(rom_addr), 64'h100);
    dec_if.out_ready = 1'b1;
    cyc(1);
    expect_head("rd_a", 12'h100);
    cyc(1);
    expect_head("rd_b", 12'h104);

    // Wrap-around at the top of the address space.
    do_redirect(12'hFFC);
    chk("wrap_bubble", 64'(dec_if.out_valid), 64'd0);
    cyc(1);
    expect_head("wrap_a", 12'hFFC);
    cyc(1);
    expect_head("wrap_b", 12'h000);
    cyc(1);
    expect_head("wrap_c", 12'h004);

    // Misaligned redirect target.
    do_redirect(12'h102);
    chk("mis_pulse", 64'(misalign_err), 64'd1);
    chk("mis_rom_addr", 64'(rom_addr), 64'h100);
    cyc(1);
    chk("mis_clear", 64'(misalign_err), 64'd0);
    expect_head("mis_head", 12'h100);

    // Halt at 0x010.
    do_redirect(12'h010);
    halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("halt_valid", 64'(dec_if.out_valid), 64'd0);
      chk("halt_rom_addr", 64'(rom_addr), 64'h010);
    end
    halt = 1'b0;
    cyc(1);
    expect_head("halt_resume", 12'h010);
    cyc(2);
    halt = 1'b1;
    cyc(2);
    chk("halt_drained", 64'(dec_if.out_valid), 64'd0);
    halt = 1'b0;

    // Reset mid-stream.
    cyc(3);
    #2 rst_n = 1'b0;
    #1 chk("rst3_valid", 64'(dec_if.out_valid), 64'd0);
    chk("rst3_rom_addr", 64'(rom_addr), 64'h000);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Mixed ready/halt pattern with one redirect in the middle.
    for (int i = 0; i < 16; i++) begin
      dec_if.out_ready = rdy_pat[i];
      halt             = halt_pat[i];
      redirect_valid   = (i == 9);
      redirect_pc      = 12'h3F1;
      cyc(1);
    end
    redirect_valid   = 1'b0;
    halt             = 1'b0;
    dec_if.out_ready = 1'b1;
    cyc(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
